dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder slice.
//
// Contents:
//   WORD_W      - storage / data-bus word width (32)
//   WAIT_MAX    - largest supported WAIT_STATES value (15)
//   CNT_W       - width of the wait-state down-counter
//   word_t      - one storage word
//   memState_t  - responder FSM state encoding
//   idxWidth()  - word-index width for a given storage depth
package mips_mem_pkg;

  localparam int WORD_W   = 32;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } memState_t;

  // A one-word array still needs a 1-bit index so port widths stay legal.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: DEPTH x 32 bits.
// Writes happen on the rising clock edge; reads are combinational.
// Contents are deliberately not reset.
//
// Ports:
//   clk     in   clock
//   wrEn    in   write enable, sampled on the rising edge
//   wrIdx   in   word index written when wrEn=1
//   wrData  in   word to write
//   rdIdx   in   word index read combinationally
//   rdData  out  word currently stored at rdIdx
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int IDX_W = idxWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  word_t            wrData,
  input  logic [IDX_W-1:0] rdIdx,
  output word_t            rdData
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// A request is accepted in IDLE, held for WAIT_STATES extra cycles in BUSY,
// then the storage access is performed on the BUSY-exit edge and the result
// is presented in RESP until the initiator takes it.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; req_ready=1 (once out of reset)
//   BUSY  | request latched; wait counter counting down to zero
//   RESP  | response held on resp_*; waiting for resp_ready
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   initiator presents a request
//   req_ready   out  request accepted this cycle (IDLE only)
//   req_write   in   1 = store word, 0 = load word
//   req_addr    in   byte address
//   req_wdata   in   store data
//   resp_valid  out  response presented
//   resp_ready  in   initiator accepts the response
//   resp_rdata  out  load data; 0 for stores and errors
//   resp_err    out  misaligned or out-of-range request
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = idxWidth(DEPTH);

  // WAIT_STATES is expected in 0..WAIT_MAX; the counter holds exactly that range.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  memState_t        state;
  logic [CNT_W-1:0] waitCnt;
  logic             outOfReset;

  logic             latWrite;
  word_t            latAddr;
  word_t            latWdata;

  logic             addrErr;
  logic [IDX_W-1:0] wordIdx;
  logic             commit;
  logic             memWrEn;
  word_t            memRdata;

  // outOfReset keeps req_ready low during reset and until the first edge
  // after release, even though the state already reads IDLE.
  assign req_ready = (state == ST_IDLE) && outOfReset;

  // Range check uses the full word address so high address bits cannot
  // alias into the array; only afterwards is the narrow index used.
  assign addrErr = (latAddr[1:0] != 2'b00) ||
                   ({2'b00, latAddr[31:2]} >= 32'(DEPTH));
  assign wordIdx = latAddr[IDX_W+1:2];

  assign commit  = (state == ST_BUSY) && (waitCnt == '0);
  assign memWrEn = commit && latWrite && !addrErr;

  dmem_array #(
    .DEPTH (DEPTH)
  ) uArray (
    .clk    (clk),
    .wrEn   (memWrEn),
    .wrIdx  (wordIdx),
    .wrData (latWdata),
    .rdIdx  (wordIdx),
    .rdData (memRdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      waitCnt    <= '0;
      outOfReset <= 1'b0;
      latWrite   <= 1'b0;
      latAddr    <= '0;
      latWdata   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      outOfReset <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            latWrite <= req_write;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            waitCnt  <= WAIT_LOAD;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
          end else begin
            // Terminal count: the array write (if any) lands on this same
            // edge, and a load captures the pre-edge contents.
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= addrErr;
            resp_rdata <= (addrErr || latWrite) ? '0 : memRdata;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Two instances share clock and reset: dut (WAIT_STATES=2) and dutZ
// (WAIT_STATES=0, back-to-back timing).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        zReqValid, zReqReady, zReqWrite;
  logic [31:0] zReqAddr, zReqWdata;
  logic        zRespValid, zRespReady, zRespErr;
  logic [31:0] zRespRdata;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) dutZ (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (zReqValid),
    .req_ready  (zReqReady),
    .req_write  (zReqWrite),
    .req_addr   (zReqAddr),
    .req_wdata  (zReqWdata),
    .resp_valid (zRespValid),
    .resp_ready (zRespReady),
    .resp_rdata (zRespRdata),
    .resp_err   (zRespErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One full transaction on dut. Inputs are scrambled right after the
  // acceptance edge; response latency must be WAIT_STATES+1 = 3.
  task automatic transact(input string tag, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expRdata,
                          input logic expErr);
    int waitCnt;
    int lat;
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 32'hFFFF_FFF0;
    req_wdata = ~wdata;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd3);
    check({tag, "/rdata"}, resp_rdata, expRdata);
    check({tag, "/err"}, 32'(resp_err), 32'(expErr));
    if (resp_ready) begin
      tick();
      check({tag, "/validDrop"}, 32'(resp_valid), 32'd0);
      check({tag, "/idle"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[$];
    int rsp[$];

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    zReqValid  = 1'b0;
    zReqWrite  = 1'b0;
    zReqAddr   = '0;
    zReqWdata  = '0;
    zRespReady = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst/reqReady", 32'(req_ready), 32'd0);
    check("rst/respValid", 32'(resp_valid), 32'd0);
    check("rst/rdata", resp_rdata, 32'd0);
    check("rst/err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release/readyBeforeEdge", 32'(req_ready), 32'd0);
    tick();
    check("release/readyAfterEdge", 32'(req_ready), 32'd1);
    check("release/zReadyAfterEdge", 32'(zReqReady), 32'd1);

    // WAIT_STATES=0: store, then back-to-back loads
    zReqValid = 1'b1;
    zReqWrite = 1'b1;
    zReqAddr  = 32'h0000_0008;
    zReqWdata = 32'h0BAD_F00D;
    tick();
    zReqValid = 1'b0;
    zReqWrite = 1'b0;
    tick();
    check("ws0st/respValid", 32'(zRespValid), 32'd1);
    check("ws0st/rdata", zRespRdata, 32'd0);
    check("ws0st/err", 32'(zRespErr), 32'd0);
    tick();
    check("ws0st/idle", 32'(zReqReady), 32'd1);

    zReqValid = 1'b1;
    zReqAddr  = 32'h0000_0008;
    for (int c = 0; c < 10; c++) begin
      if (zReqReady) acc.push_back(c);
      tick();
      if (zRespValid) begin
        rsp.push_back(c);
        check("ws0ld/rdata", zRespRdata, 32'h0BAD_F00D);
      end
    end
    zReqValid = 1'b0;
    repeat (3) tick();
    check("ws0ld/accepts", 32'(acc.size()), 32'd4);
    check("ws0ld/responses", 32'(rsp.size()), 32'd3);
    if (acc.size() >= 3) begin
      check("ws0ld/spacing1", 32'(acc[1] - acc[0]), 32'd3);
      check("ws0ld/spacing2", 32'(acc[2] - acc[1]), 32'd3);
    end
    if (acc.size() >= 1 && rsp.size() >= 1) begin
      check("ws0ld/latency", 32'(rsp[0] - acc[0]), 32'd1);
    end

    // WAIT_STATES=2: store/load, errors, boundaries
    transact("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
    transact("ld10", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    transact("ld13", 1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b1);
    transact("ld10b", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    transact("st00", 1'b1, 32'h0000_0000, 32'h1111_2222, 32'd0, 1'b0);
    transact("st400", 1'b1, 32'h0000_0400, 32'h5555_5555, 32'd0, 1'b1);
    transact("ld00", 1'b0, 32'h0000_0000, 32'd0, 32'h1111_2222, 1'b0);
    transact("st3fc", 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'd0, 1'b0);
    transact("ld3fc", 1'b0, 32'h0000_03FC, 32'd0, 32'hA5A5_A5A5, 1'b0);
    transact("st12", 1'b1, 32'h0000_0012, 32'h7777_7777, 32'd0, 1'b1);
    transact("ld10c", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // Response stall: resp_ready low for 5 RESP cycles
    resp_ready = 1'b0;
    transact("stall", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall/respValid", 32'(resp_valid), 32'd1);
      check("stall/rdata", resp_rdata, 32'hDEAD_BEEF);
      check("stall/err", 32'(resp_err), 32'd0);
      check("stall/reqReady", 32'(req_ready), 32'd0);
      if (i < 4) tick();
    end
    resp_ready = 1'b1;
    tick();
    check("stall/validDrop", 32'(resp_valid), 32'd0);
    check("stall/idle", 32'(req_ready), 32'd1);

    // Reset while a store is waiting in BUSY
    transact("st20", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'd0, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h1234_5678;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst/respValid", 32'(resp_valid), 32'd0);
    check("midrst/rdata", resp_rdata, 32'd0);
    check("midrst/err", 32'(resp_err), 32'd0);
    check("midrst/reqReady", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst/readyAfter", 32'(req_ready), 32'd1);
    transact("ld20", 1'b0, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
